// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg
// Shared definitions for the I2C target block: protocol FSM states, CPU
// register offsets within the block window, and STATUS/CTRL bit positions.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK
    } state_e;

    // Byte offsets inside the block's 256-byte CPU window
    localparam logic [7:0] REG_BANK_OFS = 8'h00;
    localparam logic [7:0] STATUS_OFS   = 8'h40;
    localparam logic [7:0] CTRL_OFS     = 8'h44;

    // STATUS bits
    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_WR_DONE_BIT = 1;
    localparam int STAT_RD_DONE_BIT = 2;
    localparam int STAT_PTR_LSB     = 4;

    // CTRL bits
    localparam int CTRL_WR_IE_BIT = 0;
    localparam int CTRL_RD_IE_BIT = 1;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync
// Brings the asynchronous SCL/SDA pad inputs into the clk domain and derives
// the single-cycle bus events used by the protocol FSM.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   scl_in, sda_in    raw pad inputs
//   sda               synchronized SDA level (data sample source)
//   scl_rise/scl_fall one-cycle strobes on SCL edges
//   start_p/stop_p    one-cycle strobes on START / STOP conditions
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_p,
    output logic stop_p
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_dly_q, scl_dly_d;
    logic                   sda_dly_q, sda_dly_d;
    logic                   scl;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign scl_sync_d[gi] = scl_in;
                assign sda_sync_d[gi] = sda_in;
            end else begin : g_rest
                assign scl_sync_d[gi] = scl_sync_q[gi-1];
                assign sda_sync_d[gi] = sda_sync_q[gi-1];
            end
        end
    endgenerate

    assign scl = scl_sync_q[SYNC_STAGES-1];
    assign sda = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_dly_d = scl;
        sda_dly_d = sda;
    end

    // Reset to the idle-bus level so leaving reset never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_dly_q  <= scl_dly_d;
            sda_dly_q  <= sda_dly_d;
        end
    end

    assign scl_rise = scl & ~scl_dly_q;
    assign scl_fall = ~scl & scl_dly_q;
    // SCL must be high in both samples so an SDA change near an SCL edge is not a START/STOP
    assign start_p  = scl & scl_dly_q & ~sda & sda_dly_q;
    assign stop_p   = scl & scl_dly_q & sda & ~sda_dly_q;

endmodule

// File: rtl/i2c_target.sv
// i2c_target
// I2C target exposing a byte register bank to an external controller and to
// the CPU. First written byte after the address sets the register pointer,
// further bytes write reg[ptr++]; reads return reg[ptr++].
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   mem_addr/wdata/we/re       CPU bus; mem_rdata is 0 when not selected
//   i2c_sda_in/out/oe          open-drain SDA (out fixed 0, oe=1 pulls low)
//   i2c_scl_in                 SCL input (no clock stretching)
//   irq                        (wr_done & wr_ie) | (rd_done & rd_ie)
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [31:0] I2C_TGT_BASE_ADDR = 32'h40005000,
    parameter logic [6:0]  DEV_ADDR          = 7'h42,
    parameter int          REG_NUM           = 8,
    parameter int          SYNC_STAGES       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    input  logic        i2c_sda_in,
    output logic        i2c_sda_out,
    output logic        i2c_sda_oe,
    input  logic        i2c_scl_in,
    output logic        irq
);

    localparam int         IDX_W     = $clog2(REG_NUM);
    localparam logic [5:0] REG_NUM_W = 6'(REG_NUM);

    logic sda, scl_rise, scl_fall, start_p, stop_p;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (i2c_scl_in),
        .sda_in   (i2c_sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_p  (start_p),
        .stop_p   (stop_p)
    );

    state_e           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       regs_q [REG_NUM];
    logic [7:0]       regs_d [REG_NUM];
    logic             sda_oe_q, sda_oe_d;
    logic             wr_act_q, wr_act_d;   // current transfer addressed for write
    logic             rd_act_q, rd_act_d;   // current transfer addressed for read
    logic             wr_done_q, wr_done_d;
    logic             rd_done_q, rd_done_d;
    logic             wr_ie_q, wr_ie_d;
    logic             rd_ie_q, rd_ie_d;

    // ---------------- CPU decode ----------------
    logic [7:0]       ofs;
    logic [5:0]       reg_word;
    logic [IDX_W-1:0] reg_idx;
    logic             blk_hit, reg_hit, status_hit, ctrl_hit;
    logic [31:0]      status_word;
    logic             unused_wdata;

    assign ofs        = mem_addr[7:0];
    assign blk_hit    = (mem_addr[31:8] == I2C_TGT_BASE_ADDR[31:8]) && (ofs[1:0] == 2'b00);
    // Addresses below the bank wrap to large word numbers and miss
    assign reg_word   = ofs[7:2] - REG_BANK_OFS[7:2];
    assign reg_idx    = reg_word[IDX_W-1:0];
    assign reg_hit    = blk_hit && (reg_word < REG_NUM_W);
    assign status_hit = blk_hit && (ofs == STATUS_OFS);
    assign ctrl_hit   = blk_hit && (ofs == CTRL_OFS);
    assign unused_wdata = ^mem_wdata[31:8];

    always_comb begin
        status_word                              = '0;
        status_word[STAT_BUSY_BIT]               = (state_q != ST_IDLE);
        status_word[STAT_WR_DONE_BIT]            = wr_done_q;
        status_word[STAT_RD_DONE_BIT]            = rd_done_q;
        status_word[STAT_PTR_LSB +: IDX_W]       = ptr_q;
    end

    always_comb begin
        mem_rdata = '0;
        if (mem_re) begin
            if (reg_hit) begin
                mem_rdata[7:0] = regs_q[reg_idx];
            end else if (status_hit) begin
                mem_rdata = status_word;
            end else if (ctrl_hit) begin
                mem_rdata[CTRL_WR_IE_BIT] = wr_ie_q;
                mem_rdata[CTRL_RD_IE_BIT] = rd_ie_q;
            end
        end
    end

    // ---------------- next state ----------------
    logic [7:0] rx_byte;
    assign rx_byte = {shift_q[6:0], sda};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        regs_d    = regs_q;
        sda_oe_d  = sda_oe_q;
        wr_act_d  = wr_act_q;
        rd_act_d  = rd_act_q;
        wr_done_d = wr_done_q;
        rd_done_d = rd_done_q;
        wr_ie_d   = wr_ie_q;
        rd_ie_d   = rd_ie_q;

        // CPU side first: bus-side updates below override on collision
        if (mem_we && reg_hit) begin
            regs_d[reg_idx] = mem_wdata[7:0];
        end
        if (mem_we && ctrl_hit) begin
            wr_ie_d = mem_wdata[CTRL_WR_IE_BIT];
            rd_ie_d = mem_wdata[CTRL_RD_IE_BIT];
        end
        if (mem_we && status_hit) begin
            if (mem_wdata[STAT_WR_DONE_BIT]) wr_done_d = 1'b0;
            if (mem_wdata[STAT_RD_DONE_BIT]) rd_done_d = 1'b0;
        end

        if (start_p) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            wr_act_d  = 1'b0;
            rd_act_d  = 1'b0;
        end else if (stop_p) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            if (wr_act_q) wr_done_d = 1'b1;
            if (rd_act_q) rd_done_d = 1'b1;
            wr_act_d = 1'b0;
            rd_act_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == ST_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_d = ST_ADDR_ACK;
                                    if (rx_byte[0]) rd_act_d = 1'b1;
                                    else            wr_act_d = 1'b1;
                                end else begin
                                    state_d = ST_IDLE;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_d   = rx_byte[IDX_W-1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                regs_d[ptr_q] = rx_byte;
                                ptr_d         = ptr_q + IDX_W'(1);
                                state_d       = ST_WR_ACK;
                            end
                        end
                    end
                end

                // First SCL fall after bit 8 starts the ACK pulse, the next one ends it
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            if (state_q == ST_ADDR_ACK && rd_act_q) begin
                                // Copy out so CPU writes cannot disturb the byte in flight
                                shift_d   = regs_q[ptr_q];
                                sda_oe_d  = ~regs_q[ptr_q][7];
                                bit_cnt_d = '0;
                                state_d   = ST_RD_DATA;
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end

                // bit_cnt counts SCL rises seen by the controller for this byte
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + IDX_W'(1);
                            state_d  = ST_RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (scl_rise && sda) begin
                        state_d  = ST_IDLE;
                        sda_oe_d = 1'b0;
                    end else if (scl_fall) begin
                        shift_d   = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                        bit_cnt_d = '0;
                        state_d   = ST_RD_DATA;
                    end
                end

                ST_IDLE: begin
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            wr_act_q  <= 1'b0;
            rd_act_q  <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            wr_ie_q   <= 1'b0;
            rd_ie_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            wr_act_q  <= wr_act_d;
            rd_act_q  <= rd_act_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            wr_ie_q   <= wr_ie_d;
            rd_ie_q   <= rd_ie_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_regs
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) regs_q[gi] <= '0;
                else        regs_q[gi] <= regs_d[gi];
            end
        end
    endgenerate

    assign i2c_sda_out = 1'b0;
    assign i2c_sda_oe  = sda_oe_q;
    assign irq         = (wr_done_q & wr_ie_q) | (rd_done_q & rd_ie_q);

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) for the I2C master peripheral. Exposes a small byte register bank to an external I2C controller and to the CPU via the standard peripheral bus (mem_addr/mem_we/mem_re).
- Used for SoC-to-SoC links and for loopback verification of the I2C master over uio[5:4].
- Open-drain SDA only. SCL is input-only; no clock stretching.

Parameters:
- I2C_TGT_BASE_ADDR, 32'h40005000, CPU base address of the block.
- DEV_ADDR, 7'h42, 7-bit I2C device address.
- REG_NUM, 8, number of byte registers; must be a power of 2 and at most 16.
- SYNC_STAGES, 2, flip-flop stages on SCL/SDA inputs.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  in  32  CPU address.
- mem_wdata  in  32  CPU write data.
- mem_we  in  1  CPU write strobe.
- mem_re  in  1  CPU read strobe.
- mem_rdata  out  32  CPU read data; 0 when not selected.
- i2c_sda_in  in  1  SDA pad input.
- i2c_sda_out  out  1  constant 0 (open-drain).
- i2c_sda_oe  out  1  1 = pull SDA low.
- i2c_scl_in  in  1  SCL pad input.
- irq  out  1  level: (wr_done & wr_ie) | (rd_done & rd_ie).

Behaviour:
- Reset values: registers 0, ptr 0, status 0, sda_oe 0, sda_out 0, irq 0, mem_rdata 0, state IDLE. rst_n mid-transfer releases SDA immediately.
- Clock ratio: clk must be at least 10x SCL frequency.
- Input conditioning: SCL/SDA pass through SYNC_STAGES flops, then one delay flop for edge detect.
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - Data is sampled on the SCL rising edge. SDA drive changes only on the SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- START (including repeated START) from any state -> ADDR, bit count cleared, SDA released.
- STOP from any state -> IDLE, SDA released. A STOP that ends an addressed write sets wr_done; one that ends an addressed read sets rd_done.
- ADDR: shift 8 bits MSB first.
  - [7:1] != DEV_ADDR -> IDLE, no ACK; ignore the bus until the next START.
  - Match with R/W=0 -> ADDR_ACK, then PTR.
  - Match with R/W=1 -> ADDR_ACK, then RD_DATA; load shift register with reg[ptr] on the ACK falling edge.
- ACK drive: sda_oe=1 from the SCL falling edge after bit 8 until the next SCL falling edge.
- PTR: ptr <= byte[$clog2(REG_NUM)-1:0]; upper bits ignored; ACK.
- WR_DATA: each byte is written to reg[ptr] on the 8th SCL rising edge, then ptr <= (ptr+1) mod REG_NUM. Always ACK.
- RD_DATA: drive ~bit (oe = ~bit) for 8 bits. In RD_ACK, sample the controller's ACK on SCL rising.
  - ACK (0): ptr+1 wraps; reload next byte; continue.
  - NACK (1): -> IDLE with SDA released.
  - ptr increments after each byte sent.
- CPU map (word offsets), reads combinational when mem_re and address hit:
  - 0x00 + 4*i: reg[i] in bits [7:0]; RW.
  - 0x40 STATUS: bit0 busy (state not IDLE), bit1 wr_done (W1C), bit2 rd_done (W1C), bits[7:4] ptr (RO).
  - 0x44 CTRL: bit0 wr_ie, bit1 rd_ie; RW; reset 0.
- Simultaneous events:
  - CPU write and I2C write to the same reg in one cycle: I2C wins.
  - W1C and hardware set of the same status bit in one cycle: set wins.
  - CPU write to a register currently being shifted out does not affect the byte in flight.

Decomposition:
- Package i2c_target_pkg: state enum, register offsets (REG_BANK_OFS, STATUS_OFS, CTRL_OFS), status bit indices.
- Sub-module i2c_line_sync: synchronizers, edge detect, START/STOP pulses, sampled SCL rise/fall strobes.

Test Plan:
- Addressed write: S, 0x84 (0x42+W), ptr 0x02, data 0xA5, 0x5A, P -> ACK on all 4 bytes; CPU reads reg2=0xA5, reg3=0x5A; STATUS=0x42 (ptr 4, wr_done); irq=1 with wr_ie=1.
- Combined read: CPU preloads reg7=0x11, reg0=0x22. Sequence S, 0x84, ptr 0x07, Sr, 0x85, read 2 bytes (ACK then NACK), P -> bus returns 0x11 then 0x22 (wrap); rd_done=1; SDA released after NACK.
- Address mismatch: S, 0x90, 0x33, P -> sda_oe stays 0 throughout; registers unchanged; busy is 0 after the address byte.
- Pointer truncation plus W1C: write ptr 0xFB, data 0x77 -> reg3=0x77. CPU writes STATUS bit1=1 -> wr_done=0 and irq=0.
- Collision: CPU writes reg1=0xCC in the same cycle as the I2C commit of 0x3C to reg1 -> reg1=0x3C.
- Reset mid-read: assert rst_n=0 during the 4th bit of a read byte -> sda_oe=0 within the reset assertion; after release, state IDLE, ptr 0, all regs 0.
